// File: rtl/tipi_wreg_latch_if.sv
// TI-bus write-side signal bundle: strobe, address selects, data, Pi acks,
// and the latched register / status outputs seen by the Pi side.
interface tipi_wreg_latch_if;
  logic       ti_we_n;
  logic       a_sel;
  logic       b_sel;
  logic       c_sel;
  logic       d_sel;
  logic [7:0] ti_data;
  logic [3:0] ack;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [7:0] c_reg;
  logic [7:0] d_reg;
  logic [3:0] wr_pulse;
  logic [3:0] dirty;

  // Driver of the TI bus and Pi acks (bench / surrounding decode logic)
  modport master (
    output ti_we_n, a_sel, b_sel, c_sel, d_sel, ti_data, ack,
    input  a_reg, b_reg, c_reg, d_reg, wr_pulse, dirty
  );

  // The write-register latch itself
  modport slave (
    input  ti_we_n, a_sel, b_sel, c_sel, d_sel, ti_data, ack,
    output a_reg, b_reg, c_reg, d_reg, wr_pulse, dirty
  );
endinterface

// File: rtl/tipi_wreg_latch.sv
// Captures asynchronous TI CPU writes into four 8-bit registers (A..D).
// Strobe, selects and data share one synchronizer depth so they stay aligned;
// a small FSM qualifies the low pulse length, then commits the value sampled
// on the last synced-low cycle, pulses wr_pulse and sets a sticky dirty bit
// that the Pi side clears with ack.
module tipi_wreg_latch #(
  parameter int         SYNC_STAGES = 2,     // >= 2
  parameter int         MIN_LOW     = 2,     // >= 1
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic           clk,
  input  logic           reset,
  tipi_wreg_latch_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (MIN_LOW < 2) ? 1 : $clog2(MIN_LOW + 1);
  localparam logic [CNT_W-1:0] MIN_LOW_C = CNT_W'(MIN_LOW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOW    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Synchronizer chains (index SYNC_STAGES-1 is the synced output)
  logic [SYNC_STAGES-1:0]             we_sync;
  logic [SYNC_STAGES-1:0][3:0]        sel_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync;

  logic              we_s;
  logic [3:0]        sel_s;
  logic [DATA_W-1:0] data_s;

  // Control state
  state_t            state;
  logic              we_prev;
  logic [CNT_W-1:0]  low_cnt;

  // Holding register: sel/data from the most recent synced-low cycle
  logic [3:0]        hold_sel;
  logic [DATA_W-1:0] hold_data;

  // Outputs
  logic [3:0][DATA_W-1:0] regs_q;
  logic [3:0]             wr_pulse_q;
  logic [3:0]             dirty_q;

  // Decode helpers
  logic       fall_edge;
  logic       hold_load;
  logic       commit_now;
  logic [3:0] commit_oh;

  // Fixed priority A > B > C > D; returns a one-hot (or zero) mask
  function automatic logic [3:0] pick_sel(input logic [3:0] s);
    logic [3:0] r;
    r = 4'b0000;
    if (s[0])      r = 4'b0001;
    else if (s[1]) r = 4'b0010;
    else if (s[2]) r = 4'b0100;
    else if (s[3]) r = 4'b1000;
    return r;
  endfunction

  // Input synchronizers; all three chains have identical depth
  always_ff @(posedge clk) begin
    we_sync   <= {we_sync[SYNC_STAGES-2:0], bus.ti_we_n};
    sel_sync  <= {sel_sync[SYNC_STAGES-2:0],
                  {bus.d_sel, bus.c_sel, bus.b_sel, bus.a_sel}};
    data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ti_data};
  end

  assign we_s   = we_sync[SYNC_STAGES-1];
  assign sel_s  = sel_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Edge detect, hold-register load and commit decode for the current cycle
  always_comb begin
    fall_edge  = we_prev && !we_s;
    hold_load  = ((state == IDLE) && fall_edge) || ((state == LOW) && !we_s);
    commit_now = (state == LOW) && we_s && (low_cnt >= MIN_LOW_C);
    commit_oh  = commit_now ? pick_sel(hold_sel) : 4'b0000;
  end

  // Holding register tracks the bus while the synced strobe is low
  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_sel  <= sel_s;
      hold_data <= data_s;
    end
  end

  // Write FSM; the register write, pulse and dirty set land on the edge that
  // enters COMMIT, so COMMIT is the single cycle in which they are visible
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we_prev <= 1'b0;
      low_cnt <= '0;
    end else begin
      we_prev <= we_s;
      case (state)
        IDLE: begin
          if (fall_edge) begin
            state   <= LOW;
            low_cnt <= CNT_W'(1);
          end
        end
        LOW: begin
          if (!we_s) begin
            if (low_cnt < MIN_LOW_C) low_cnt <= low_cnt + CNT_W'(1);
          end else if (commit_now) begin
            state <= COMMIT;
          end else begin
            state <= IDLE;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Register file, update pulses and sticky dirty flags (set beats ack)
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= {4{RESET_VALUE}};
      wr_pulse_q <= 4'b0000;
      dirty_q    <= 4'b0000;
    end else begin
      wr_pulse_q <= commit_oh;
      dirty_q    <= (dirty_q & ~bus.ack) | commit_oh;
      for (int i = 0; i < 4; i++) begin
        if (commit_oh[i]) regs_q[i] <= hold_data;
      end
    end
  end

  assign bus.a_reg    = regs_q[0];
  assign bus.b_reg    = regs_q[1];
  assign bus.c_reg    = regs_q[2];
  assign bus.d_reg    = regs_q[3];
  assign bus.wr_pulse = wr_pulse_q;
  assign bus.dirty    = dirty_q;

endmodule

// File: tb/tb_tipi_wreg_latch.sv
// Bench for tipi_wreg_latch: drives TI write cycles, queues the expected
// commit for each one, and a monitor pops and compares on every wr_pulse.
module tb_tipi_wreg_latch;

  localparam int         SYNC_STAGES = 2;
  localparam int         MIN_LOW     = 2;
  localparam logic [7:0] RESET_VALUE = 8'h00;

  typedef struct packed {
    logic [3:0] pulse;
    logic [7:0] data;
  } sb_item_t;

  logic clk;
  logic reset;
  tipi_wreg_latch_if bus();

  tipi_wreg_latch #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_LOW    (MIN_LOW),
    .RESET_VALUE(RESET_VALUE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  sb_item_t   sb[$];
  logic [7:0] exp_reg[4];
  logic [3:0] exp_dirty;
  logic [3:0] prev_pulse;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_of(input logic [3:0] oh);
    case (oh)
      4'b0001: return bus.a_reg;
      4'b0010: return bus.b_reg;
      4'b0100: return bus.c_reg;
      4'b1000: return bus.d_reg;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic logic [3:0] prio(input logic [3:0] s);
    if (s[0]) return 4'b0001;
    if (s[1]) return 4'b0010;
    if (s[2]) return 4'b0100;
    if (s[3]) return 4'b1000;
    return 4'b0000;
  endfunction

  // Monitor: each pulse must match the next queued commit
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse = 4'b0000;
    end else begin
      if (prev_pulse != 4'b0000) chk("pulse_width", bus.wr_pulse, 4'b0000);
      if (bus.wr_pulse != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", bus.wr_pulse, 4'b0000);
        end else begin
          sb_item_t it;
          it = sb.pop_front();
          chk("sb_pulse", bus.wr_pulse, it.pulse);
          chk("sb_data", reg_of(it.pulse), it.data);
        end
      end
      prev_pulse = bus.wr_pulse;
    end
  end

  task automatic check_all(input string tag);
    chk({tag, "_a"}, bus.a_reg, exp_reg[0]);
    chk({tag, "_b"}, bus.b_reg, exp_reg[1]);
    chk({tag, "_c"}, bus.c_reg, exp_reg[2]);
    chk({tag, "_d"}, bus.d_reg, exp_reg[3]);
    chk({tag, "_dirty"}, bus.dirty, exp_dirty);
  endtask

  // One TI write: strobe low for low_cyc clocks, ack_val presented in the commit cycle
  task automatic ti_write(input string tag, input logic [3:0] sel, input logic [7:0] d,
                          input int low_cyc, input logic [3:0] ack_val);
    logic [3:0] oh;
    int         lat;
    bit         valid;
    valid = (low_cyc >= MIN_LOW);
    oh    = valid ? prio(sel) : 4'b0000;
    {bus.d_sel, bus.c_sel, bus.b_sel, bus.a_sel} = sel;
    bus.ti_data = d;
    bus.ti_we_n = 1'b0;
    repeat (low_cyc) @(negedge clk);
    bus.ti_we_n = 1'b1;
    {bus.d_sel, bus.c_sel, bus.b_sel, bus.a_sel} = 4'b0000;
    bus.ti_data = ~d;
    if (oh != 4'b0000) sb.push_back('{pulse: oh, data: d});
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.wr_pulse != 4'b0000 && lat == 0) lat = n;
      if (n == 2) bus.ack = ack_val;
      if (n == 3) bus.ack = 4'b0000;
    end
    chk({tag, "_latency"}, lat, (oh != 4'b0000) ? SYNC_STAGES + 1 : 0);
    if (oh != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (oh[i]) exp_reg[i] = d;
    end
    exp_dirty = (exp_dirty & ~ack_val) | oh;
    check_all(tag);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    bus.ti_we_n = 1'b1;
    {bus.d_sel, bus.c_sel, bus.b_sel, bus.a_sel} = 4'b0000;
    bus.ti_data = 8'h00;
    bus.ack     = 4'b0000;
    prev_pulse  = 4'b0000;
    for (int i = 0; i < 4; i++) exp_reg[i] = RESET_VALUE;
    exp_dirty = 4'b0000;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset_pulse", bus.wr_pulse, 4'b0000);

    ti_write("t1_a", 4'b0001, 8'h5A, 4, 4'b0000);
    ti_write("t2_bc", 4'b0110, 8'hC3, 3, 4'b0000);
    ti_write("t3_glitch", 4'b1000, 8'hFF, 1, 4'b0000);
    ti_write("t4_setack", 4'b0001, 8'h3C, 3, 4'b0001);
    bus.ack = 4'b0001;
    @(negedge clk);
    bus.ack = 4'b0000;
    exp_dirty = exp_dirty & ~4'b0001;
    @(negedge clk);
    chk("t4_ack_clear", bus.dirty, exp_dirty);
    bus.ack = 4'b0001;
    @(negedge clk);
    bus.ack = 4'b0000;
    @(negedge clk);
    chk("t4_ack_noop", bus.dirty, exp_dirty);

    // Reset while the FSM is in LOW, strobe held low through release
    {bus.d_sel, bus.c_sel, bus.b_sel, bus.a_sel} = 4'b1000;
    bus.ti_data = 8'h77;
    bus.ti_we_n = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_reg[i] = RESET_VALUE;
    exp_dirty = 4'b0000;
    repeat (6) @(negedge clk);
    chk("t5_pulse", bus.wr_pulse, 4'b0000);
    check_all("t5_held");
    bus.ti_we_n = 1'b1;
    {bus.d_sel, bus.c_sel, bus.b_sel, bus.a_sel} = 4'b0000;
    repeat (6) @(negedge clk);
    check_all("t5_after_rise");
    ti_write("t5_rewrite", 4'b1000, 8'h77, 2, 4'b0000);

    ti_write("t6_nosel", 4'b0000, 8'h12, 3, 4'b0000);
    ti_write("all_sel", 4'b1111, 8'hA5, 2, 4'b0000);
    ti_write("c_only", 4'b0100, 8'h81, 5, 4'b1111);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] s;
      logic [7:0] d;
      int         l;
      s = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      l = $urandom_range(1, 4);
      ti_write("rnd", s, d, l, 4'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
